// File: rtl/bscan_dr_controller.sv
// JTAG user-DR controller: 8-bit scans upload bytes into a FWFT FIFO, longer scans read back
// the solver result LSB-first. Optional status byte in readback: define BSCAN_DR_STATUS_EN.
module bscan_dr_controller #(
    parameter int unsigned RESULT_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                    tck,
    input  logic                    rst_n,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic                    tdi,
    output logic                    tdo,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    input  logic [RESULT_WIDTH-1:0] result_data,
    input  logic                    result_valid,
    output logic                    overflow
);

    localparam int unsigned WBase = (RESULT_WIDTH > 8) ? RESULT_WIDTH : 8;
`ifdef BSCAN_DR_STATUS_EN
    localparam int unsigned W = WBase + 8;
`else
    localparam int unsigned W = WBase;
`endif
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthVal = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    sr_q, sr_d, cap_val;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic            load, shift, commit;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            empty, full, pop, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DepthVal);
    assign pop     = ~empty & byte_ready;
    // Fullness is judged before the same-cycle pop, so a push into a full FIFO is dropped.
    assign push_ok = commit & ~full;

    // ---------------- Scan FSM ----------------
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else if (test_logic_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ir_is_user) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (capture_dr) state_d = StScan;
                StScan:  if (update_dr && !capture_dr) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        commit = 1'b0;
        if (ir_is_user) begin
            case (state_q)
                StIdle: load = capture_dr;
                StScan: begin
                    load   = capture_dr;
                    shift  = shift_dr & ~capture_dr;
                    commit = update_dr & ~capture_dr & (bit_cnt_q == 6'd8);
                end
                default: ;
            endcase
        end
    end

    // ---------------- Shift register and bit counter ----------------
    always_comb begin
        cap_val = '0;
        cap_val[RESULT_WIDTH-1:0] = result_data;
`ifdef BSCAN_DR_STATUS_EN
        cap_val[RESULT_WIDTH +: 8] = {5'b0, empty, overflow_q, result_valid};
`endif
    end

`ifndef BSCAN_DR_STATUS_EN
    logic unused_result_valid;
    assign unused_result_valid = result_valid;
`endif

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            sr_d      = cap_val;
            bit_cnt_d = '0;
        end else if (shift) begin
            sr_d = {tdi, sr_q[W-1:1]};
            if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
        end
    end

    // ---------------- Upload FIFO ----------------
    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q | (commit & full);
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (test_logic_reset) begin
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge tck) begin
        if (push_ok && !test_logic_reset) begin
            mem[wr_ptr_q] <= sr_q[W-1 -: 8];
        end
    end

    assign tdo        = sr_q[0];
    assign byte_valid = ~empty;
    assign byte_data  = empty ? 8'h00 : mem[rd_ptr_q];
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bscan_dr_controller.sv
// Directed self-checking bench for bscan_dr_controller: uploads, overflow, readback, aborts,
// resets and (when BSCAN_DR_STATUS_EN is defined) the status byte.
module tb_bscan_dr_controller;

    logic        tck = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_logic_reset = 1'b0;
    logic        ir_is_user = 1'b0;
    logic        capture_dr = 1'b0;
    logic        shift_dr = 1'b0;
    logic        update_dr = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic [15:0] result_data = 16'h0000;
    logic        result_valid = 1'b0;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    bscan_dr_controller #(
        .RESULT_WIDTH(16),
        .FIFO_DEPTH  (16)
    ) dut (
        .tck             (tck),
        .rst_n           (rst_n),
        .test_logic_reset(test_logic_reset),
        .ir_is_user      (ir_is_user),
        .capture_dr      (capture_dr),
        .shift_dr        (shift_dr),
        .update_dr       (update_dr),
        .tdi             (tdi),
        .tdo             (tdo),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .result_data     (result_data),
        .result_valid    (result_valid),
        .overflow        (overflow)
    );

    always #5 tck = ~tck;

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // Full scan: capture, nbits shifts of data LSB-first, exit, update. Ends 1 ns after update edge.
    task automatic scan(input logic [15:0] data, input int nbits);
        ir_is_user = 1'b1;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            tdi = data[i];
            tick();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
        tick();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic readback(input int nbits, output logic [31:0] val);
        val        = '0;
        ir_is_user = 1'b1;
        tdi        = 1'b0;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            val[i] = tdo;
            tick();
        end
        shift_dr = 1'b0;
        tick();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({tdo, byte_valid, byte_data, overflow} !== 11'b0) begin
            $display("FAIL reset_outputs: got tdo=%b valid=%b data=%h ovf=%b, want all 0",
                     tdo, byte_valid, byte_data, overflow);
        end else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_upload();
        logic [7:0] msg [4];
        msg[0] = 8'h4C; msg[1] = 8'h36; msg[2] = 8'h38; msg[3] = 8'h0A;
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            scan({8'h00, msg[i]}, 8);
            n_checks++;
            if (byte_valid !== 1'b1 || byte_data !== msg[i]) begin
                $display("FAIL upload_byte%0d: got valid=%b data=%h, want valid=1 data=%h",
                         i, byte_valid, byte_data, msg[i]);
            end else n_pass++;
        end
        tick();
        n_checks++;
        if (byte_valid !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL upload_drained: got valid=%b ovf=%b, want 0 0", byte_valid, overflow);
        end else n_pass++;
    endtask

    task automatic test_readback();
        logic [31:0] val;
        byte_ready = 1'b0;
        scan(16'h00A5, 8);
        result_data = 16'h04D2;
        readback(16, val);
        n_checks++;
        if (val[15:0] !== 16'h04D2) begin
            $display("FAIL readback_value: got %h, want 04d2", val[15:0]);
        end else n_pass++;
        n_checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hA5) begin
            $display("FAIL readback_fifo_kept: got valid=%b data=%h, want 1 a5",
                     byte_valid, byte_data);
        end else n_pass++;
        byte_ready = 1'b1;
        tick();
        n_checks++;
        if (byte_valid !== 1'b0) begin
            $display("FAIL readback_fifo_drain: got valid=%b, want 0", byte_valid);
        end else n_pass++;
    endtask

    task automatic test_malformed();
        byte_ready = 1'b0;
        scan(16'h007F, 7);
        n_checks++;
        if (byte_valid !== 1'b0) begin
            $display("FAIL scan7_no_push: got valid=%b, want 0", byte_valid);
        end else n_pass++;
        scan(16'h01FF, 9);
        n_checks++;
        if (byte_valid !== 1'b0) begin
            $display("FAIL scan9_no_push: got valid=%b, want 0", byte_valid);
        end else n_pass++;
        // 8-bit scan abandoned by dropping the user instruction before update
        ir_is_user = 1'b1;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tdi = 1'b1;
            tick();
        end
        shift_dr   = 1'b0;
        tdi        = 1'b0;
        ir_is_user = 1'b0;
        tick();
        ir_is_user = 1'b1;
        update_dr  = 1'b1;
        tick();
        update_dr  = 1'b0;
        n_checks++;
        if (byte_valid !== 1'b0) begin
            $display("FAIL abort_no_push: got valid=%b, want 0", byte_valid);
        end else n_pass++;
    endtask

    task automatic test_overflow();
        byte_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            scan(16'(i), 8);
            if (i == 15) begin
                n_checks++;
                if (overflow !== 1'b0) begin
                    $display("FAIL overflow_at_16: got %b, want 0", overflow);
                end else n_pass++;
            end
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            $display("FAIL overflow_at_17: got %b, want 1", overflow);
        end else n_pass++;
        byte_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (byte_valid !== 1'b1 || byte_data !== 8'(i)) begin
                $display("FAIL drain_%0d: got valid=%b data=%h, want 1 %h",
                         i, byte_valid, byte_data, 8'(i));
            end else n_pass++;
            tick();
        end
        n_checks++;
        if (byte_valid !== 1'b0 || overflow !== 1'b1) begin
            $display("FAIL drain_end: got valid=%b ovf=%b, want 0 1", byte_valid, overflow);
        end else n_pass++;
    endtask

    task automatic test_tlr();
        byte_ready = 1'b0;
        scan(16'h0011, 8);
        test_logic_reset = 1'b1;
        tick();
        test_logic_reset = 1'b0;
        n_checks++;
        if (byte_valid !== 1'b0 || overflow !== 1'b0 || tdo !== 1'b0) begin
            $display("FAIL tlr_clear: got valid=%b ovf=%b tdo=%b, want 0 0 0",
                     byte_valid, overflow, tdo);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        byte_ready = 1'b0;
        for (int i = 0; i < 17; i++) scan(16'(8'h20 + i), 8);
        result_data = 16'hFFFF;
        ir_is_user  = 1'b1;
        capture_dr  = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        tdi        = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (byte_valid !== 1'b0 || tdo !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL async_reset: got valid=%b tdo=%b ovf=%b, want 0 0 0",
                     byte_valid, tdo, overflow);
        end else n_pass++;
        shift_dr = 1'b0;
        tdi      = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        byte_ready = 1'b1;
        scan(16'h0052, 8);
        n_checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h52) begin
            $display("FAIL post_reset_upload: got valid=%b data=%h, want 1 52",
                     byte_valid, byte_data);
        end else n_pass++;
        tick();
    endtask

`ifdef BSCAN_DR_STATUS_EN
    task automatic test_status();
        logic [31:0] val;
        byte_ready = 1'b0;
        for (int i = 0; i < 17; i++) scan(16'(i), 8);
        result_valid = 1'b1;
        result_data  = 16'h0003;
        readback(24, val);
        n_checks++;
        if (val[23:0] !== 24'h030003) begin
            $display("FAIL status_readback: got %h, want 030003", val[23:0]);
        end else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_upload();
        test_readback();
        test_malformed();
        test_overflow();
        test_tlr();
        test_reset_mid_scan();
`ifdef BSCAN_DR_STATUS_EN
        test_status();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
